seg_display_scheduler: RTL and testbench
========================================

// Module: seg_display_scheduler
// PURPOSE
// Schedules the 4-digit multiplexed seven-segment display of the BNN OCR board.
// Accepts classified digits from the inference core (valid/ready) and status codes
// from the top-level controller, keeps a 4-deep result history, arbitrates
// status-over-result, and time-multiplexes digits. Drives digit value/select to the
// segment encoder and anodes/decimal point to the board pins.
// PARAMETERS
// REFRESH_DIV    100_000  clk cycles per digit slot (>=2); 4 slots = 1 frame
// STATUS_FRAMES  200      frames a status code stays on screen (>=1)
// FRESH_FRAMES   100      frames the dp marks the newest result (>=1)
// PORTS
// clk           in   1  clock
// rst_n         in   1  reset, asynchronous, active-low
// res_valid     in   1  inference result offered
// res_data      in   4  classified digit 0-9 (10-15 shown as blank by encoder)
// res_ready     out  1  result accepted when res_valid && res_ready
// status_valid  in   1  one-cycle status request (error/busy code)
// status_code   in   4  status code to display
// clear         in   1  sync clear of history and status
// digit_val     out  4  value for segment encoder, current slot
// digit_blank   out  1  current slot blank (encoder forces all segments off)
// an            out  4  anodes, active-low, one-hot of current slot
// dp            out  1  decimal point, active-high
// BEHAVIOUR
// - Reset: state SHOW, hist=0, hist_vld=0, slot=0, prescaler=0, digit_val=0,
//   digit_blank=1, an=4'b1111, dp=0; res_ready=0 while rst_n low.
// - Timer: prescaler 0..REFRESH_DIV-1; slot_tick on terminal count; slot 0..3
//   wraps 3->0; frame_tick = slot_tick when slot==3.
// - res_ready = (state==SHOW) && !status_valid && !clear (combinational).
// - Accept: hist[3:1]<=hist[2:0], hist[0]<=res_data; same shift on hist_vld with
//   hist_vld[0]<=1; fresh_cnt<=FRESH_FRAMES. hist[0] = rightmost digit (slot 0).
// - States: SHOW -(status_valid)-> STATUS (latch code, stat_cnt<=STATUS_FRAMES);
//   STATUS -(stat_cnt==0 after frame_tick decrement)-> SHOW. status_valid in
//   STATUS relatches code and restarts stat_cnt. clear -> SHOW from either state.
// - Priority in one cycle: clear > status_valid > result accept; losers dropped
//   (result stays pending, not accepted).
// - Output regs update only on slot_tick, sampling the new slot value:
//   SHOW: digit_val=hist[s], digit_blank=!hist_vld[s];
//   STATUS: slot 3 shows latched code, slots 0-2 blank.
//   an = 4'b1111 if digit_blank else ~(1<<s). dp=1 only in SHOW, s==0,
//   hist_vld[0], fresh_cnt!=0. Latency: accepted result visible by next slot 0.
// - fresh_cnt/stat_cnt decrement on frame_tick, saturate at 0.
// - clear: hist_vld=0, fresh_cnt=0, stat_cnt=0; timer and slot keep running.
// - History overflow: 5th result drops oldest; no backpressure in SHOW.
// - Reset mid-frame: async return to reset values; no partial digit retained.
// STRUCTURE
// - bnn_display_pkg: disp_state_e {SHOW, STATUS}, NUM_DIGITS=4, digit_t (4b).
// - Sub-module seg_refresh_timer (REFRESH_DIV): prescaler + slot counter;
//   outputs slot[1:0], slot_tick, frame_tick.
// - Scheduler FSM, history, counters, output regs in this module.
// TESTING (REFRESH_DIV=4, STATUS_FRAMES=2, FRESH_FRAMES=2)
// - Reset release, no results -> an=4'b1111, digit_blank=1 every slot, res_ready=1.
// - Accept 7 -> by next slot 0: an=4'b1110, digit_val=7, dp=1; dp=0 after 2 frames.
// - Accept 1,2,3,4,5 -> slots 3..0 show 2,3,4,5; value 1 evicted.
// - status_valid code 0xE same cycle as res_valid -> res_ready=0, slot 3 shows E,
//   slots 0-2 blank for 2 frames, then history returns; pending result accepted.
// - clear during STATUS -> SHOW next cycle, all digits blank, an=4'b1111.
// - rst_n low mid-slot with history -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/bnn_display_pkg.sv
// Shared types and helpers for the BNN OCR board seven-segment display path.
// Imported by the refresh timer and the display scheduler.
package bnn_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] digit_t;

    typedef enum logic {
        SHOW   = 1'b0,
        STATUS = 1'b1
    } disp_state_e;

    // Active-low one-hot anode pattern for a digit slot.
    function automatic logic [3:0] anode_mask(input logic [1:0] slot);
        return ~(4'b0001 << slot);
    endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Digit refresh timebase: a prescaler producing one slot_tick every REFRESH_DIV
// cycles and a 2-bit slot counter; frame_tick marks the slot 3 -> 0 wrap.
module seg_refresh_timer
    import bnn_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] slot,
    output logic       slot_tick,
    output logic       frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERMINAL = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_reg;
    logic [1:0]    slot_reg;

    assign slot_tick  = (prescaler_reg == TERMINAL);
    assign frame_tick = slot_tick && (slot_reg == 2'd3);
    assign slot       = slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg <= '0;
            slot_reg      <= '0;
        end else if (slot_tick) begin
            prescaler_reg <= '0;
            slot_reg      <= slot_reg + 2'd1;
        end else begin
            prescaler_reg <= prescaler_reg + PW'(1);
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Multiplexed 4-digit display scheduler: keeps a short history of classified
// digits, lets status codes pre-empt it for a while, and drives one slot at a time.
module seg_display_scheduler
    import bnn_display_pkg::*;
#(
    parameter int REFRESH_DIV   = 100_000,
    parameter int STATUS_FRAMES = 200,
    parameter int FRESH_FRAMES  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    input  logic [3:0] res_data,
    output logic       res_ready,
    input  logic       status_valid,
    input  logic [3:0] status_code,
    input  logic       clear,
    output logic [3:0] digit_val,
    output logic       digit_blank,
    output logic [3:0] an,
    output logic       dp
);

    localparam int STAT_W  = $clog2(STATUS_FRAMES + 1);
    localparam int FRESH_W = $clog2(FRESH_FRAMES + 1);

    logic [1:0] slot;
    logic       slot_tick;
    logic       frame_tick;

    disp_state_e            state_reg, state_next;
    digit_t                 hist_reg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  hist_vld_reg;
    logic [STAT_W-1:0]      stat_cnt_reg;
    logic [FRESH_W-1:0]     fresh_cnt_reg;
    digit_t                 code_reg;

    logic [3:0] digit_val_reg;
    logic       digit_blank_reg;
    logic [3:0] an_reg;
    logic       dp_reg;

    logic       accept;
    logic [1:0] slot_new;
    digit_t     show_val;
    logic       show_blank;
    logic       show_dp;

    seg_refresh_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot      (slot),
        .slot_tick (slot_tick),
        .frame_tick(frame_tick)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= SHOW;
        else        state_reg <= state_next;
    end

    // FSM: next state; clear beats a status request, which beats expiry
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = SHOW;
        end else if (status_valid) begin
            state_next = STATUS;
        end else if (state_reg == STATUS && frame_tick && stat_cnt_reg <= STAT_W'(1)) begin
            state_next = SHOW;
        end
    end

    // FSM: outputs
    always_comb begin
        res_ready = rst_n && (state_reg == SHOW) && !status_valid && !clear;
    end

    assign accept = res_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist_reg[i] <= '0;
            hist_vld_reg <= '0;
        end else if (clear) begin
            hist_vld_reg <= '0;
        end else if (accept) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) hist_reg[i] <= hist_reg[i-1];
            hist_reg[0]  <= res_data;
            hist_vld_reg <= {hist_vld_reg[NUM_DIGITS-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt_reg  <= '0;
            fresh_cnt_reg <= '0;
            code_reg      <= '0;
        end else if (clear) begin
            stat_cnt_reg  <= '0;
            fresh_cnt_reg <= '0;
        end else begin
            if (status_valid) begin
                code_reg     <= status_code;
                stat_cnt_reg <= STAT_W'(STATUS_FRAMES);
            end else if (frame_tick && stat_cnt_reg != '0) begin
                stat_cnt_reg <= stat_cnt_reg - STAT_W'(1);
            end
            if (accept) begin
                fresh_cnt_reg <= FRESH_W'(FRESH_FRAMES);
            end else if (frame_tick && fresh_cnt_reg != '0) begin
                fresh_cnt_reg <= fresh_cnt_reg - FRESH_W'(1);
            end
        end
    end

    // Content for the slot the timer is about to advance into.
    always_comb begin
        slot_new   = slot + 2'd1;
        show_val   = hist_reg[slot_new];
        show_blank = !hist_vld_reg[slot_new];
        if (state_reg == STATUS) begin
            show_val   = (slot_new == 2'd3) ? code_reg : '0;
            show_blank = (slot_new != 2'd3);
        end
        show_dp = (state_reg == SHOW) && (slot_new == 2'd0) && hist_vld_reg[0]
                  && (fresh_cnt_reg != '0);
    end

    // Clear blanks the pins at once instead of waiting for the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val_reg   <= '0;
            digit_blank_reg <= 1'b1;
            an_reg          <= 4'b1111;
            dp_reg          <= 1'b0;
        end else if (clear) begin
            digit_val_reg   <= '0;
            digit_blank_reg <= 1'b1;
            an_reg          <= 4'b1111;
            dp_reg          <= 1'b0;
        end else if (slot_tick) begin
            digit_val_reg   <= show_val;
            digit_blank_reg <= show_blank;
            an_reg          <= show_blank ? 4'b1111 : anode_mask(slot_new);
            dp_reg          <= show_dp;
        end
    end

    assign digit_val   = digit_val_reg;
    assign digit_blank = digit_blank_reg;
    assign an          = an_reg;
    assign dp          = dp_reg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench for seg_display_scheduler with a 4-cycle slot: stimulus queues
// the expected pin state per slot, a monitor checks it after every slot update.
module tb_seg_display_scheduler;

    logic       clk;
    logic       rst_n;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_ready;
    logic       status_valid;
    logic [3:0] status_code;
    logic       clear;
    logic [3:0] digit_val;
    logic       digit_blank;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int unsigned n;

    typedef struct {
        logic [3:0] val;
        logic       blank;
        logic [3:0] an;
        logic       dp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    seg_display_scheduler #(
        .REFRESH_DIV  (4),
        .STATUS_FRAMES(2),
        .FRESH_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .status_valid(status_valid),
        .status_code (status_code),
        .clear       (clear),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .an          (an),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; slot updates land on every 4th one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && n != 0 && (n % 4) == 0 && sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (digit_blank !== mon_e.blank || an !== mon_e.an || dp !== mon_e.dp ||
                (!mon_e.blank && digit_val !== mon_e.val)) begin
                errors++;
                $display("FAIL slot_out n=%0d got val=%h blank=%b an=%b dp=%b expected val=%h blank=%b an=%b dp=%b",
                         n, digit_val, digit_blank, an, dp, mon_e.val, mon_e.blank, mon_e.an, mon_e.dp);
            end else begin
                $display("ok   slot_out n=%0d val=%h blank=%b an=%b dp=%b", n, digit_val, digit_blank, an, dp);
            end
        end
    end

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic wait_update();
        do @(negedge clk); while ((n % 4) != 0);
    endtask

    // Align so the next slot update is slot 0.
    task automatic sync3();
        while (((n / 4) % 4) != 3) wait_update();
    endtask

    task automatic chk1(input logic [3:0] v, input logic b, input logic [3:0] a, input logic d);
        exp_t e;
        e.val = v; e.blank = b; e.an = a; e.dp = d;
        sb.push_back(e);
        wait_update();
    endtask

    task automatic blank_frame();
        for (int i = 0; i < 4; i++) chk1(4'h0, 1'b1, 4'hF, 1'b0);
    endtask

    task automatic send(input logic [3:0] d);
        res_valid = 1'b1;
        res_data  = d;
        #1 check_now("res_ready_send", {3'b0, res_ready}, 4'h1);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; res_valid = 1'b0; res_data = '0;
        status_valid = 1'b0; status_code = '0; clear = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_now("rst_an", an, 4'hF);
        check_now("rst_blank", {3'b0, digit_blank}, 4'h1);
        check_now("rst_dp", {3'b0, dp}, 4'h0);
        check_now("rst_val", digit_val, 4'h0);
        check_now("rst_ready", {3'b0, res_ready}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_now("idle_ready", {3'b0, res_ready}, 4'h1);

        // Empty history: every slot blank.
        sync3();
        blank_frame();

        // Single result 7: slot 0 lit, dp for two frames then off.
        send(4'd7);
        sync3();
        chk1(4'd7, 1'b0, 4'hE, 1'b1); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0);
        chk1(4'd7, 1'b0, 4'hE, 1'b1); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0);
        chk1(4'd7, 1'b0, 4'hE, 1'b0); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0);

        // Clear, then five results: oldest (1) evicted.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 1; i <= 5; i++) send(4'(i));
        sync3();
        chk1(4'd5, 1'b0, 4'hE, 1'b1);
        chk1(4'd4, 1'b0, 4'hD, 1'b0);
        chk1(4'd3, 1'b0, 4'hB, 1'b0);
        chk1(4'd2, 1'b0, 4'h7, 1'b0);

        // Status E collides with a pending result 9.
        wait_update();
        status_valid = 1'b1; status_code = 4'hE;
        res_valid = 1'b1; res_data = 4'd9;
        #1 check_now("ready_vs_status", {3'b0, res_ready}, 4'h0);
        @(negedge clk);
        status_valid = 1'b0;
        #1 check_now("ready_in_status", {3'b0, res_ready}, 4'h0);
        for (int f = 0; f < 2; f++) begin
            chk1(0, 1, 4'hF, 0); chk1(0, 1, 4'hF, 0);
            chk1(4'hE, 1'b0, 4'h7, 1'b0); chk1(0, 1, 4'hF, 0);
        end
        #1 check_now("ready_after_status", {3'b0, res_ready}, 4'h1);
        @(negedge clk);
        res_valid = 1'b0;
        chk1(4'd5, 1'b0, 4'hD, 1'b0);
        chk1(4'd4, 1'b0, 4'hB, 1'b0);
        chk1(4'd3, 1'b0, 4'h7, 1'b0);
        chk1(4'd9, 1'b0, 4'hE, 1'b1);

        // Clear while a status code is showing.
        status_valid = 1'b1; status_code = 4'hA;
        @(negedge clk);
        status_valid = 1'b0; clear = 1'b1;
        #1 check_now("ready_during_clear", {3'b0, res_ready}, 4'h0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        check_now("clear_an", an, 4'hF);
        check_now("clear_blank", {3'b0, digit_blank}, 4'h1);
        check_now("clear_ready", {3'b0, res_ready}, 4'h1);
        blank_frame();

        // Asynchronous reset in the middle of a slot.
        send(4'd8);
        sync3();
        chk1(4'd8, 1'b0, 4'hE, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_now("arst_an", an, 4'hF);
        check_now("arst_blank", {3'b0, digit_blank}, 4'h1);
        check_now("arst_dp", {3'b0, dp}, 4'h0);
        check_now("arst_val", digit_val, 4'h0);
        check_now("arst_ready", {3'b0, res_ready}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sync3();
        blank_frame();

        check_now("sb_drained", 4'(sb.size()), 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
